// File: rtl/cache_pkg.sv
// Shared types, widths and line/word helpers for the direct-mapped cache controller.
package cache_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CMP   = 3'd1,
    FILL  = 3'd2,
    WRITE = 3'd3,
    RESP  = 3'd4
  } state_e;

  localparam int OFFSET_W = 2;
  localparam int BLOCK_W  = 4;
  localparam int WORD_W   = 32;
  localparam int LINE_W   = 128;

  // Word 0 sits in the most significant slot of a line, matching the memory block layout.
  function automatic logic [WORD_W-1:0] word_of_line(input logic [LINE_W-1:0] line,
                                                     input logic [OFFSET_W-1:0] off);
    logic [WORD_W-1:0] w;
    case (off)
      2'd0:    w = line[127:96];
      2'd1:    w = line[95:64];
      2'd2:    w = line[63:32];
      2'd3:    w = line[31:0];
      default: w = line[31:0];
    endcase
    return w;
  endfunction

  function automatic logic [LINE_W-1:0] set_word(input logic [LINE_W-1:0] line,
                                                 input logic [OFFSET_W-1:0] off,
                                                 input logic [WORD_W-1:0] w);
    logic [LINE_W-1:0] l;
    l = line;
    case (off)
      2'd0:    l[127:96] = w;
      2'd1:    l[95:64]  = w;
      2'd2:    l[63:32]  = w;
      2'd3:    l[31:0]   = w;
      default: l[31:0]   = w;
    endcase
    return l;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    logic [15:0] r;
    if (v == 16'hFFFF) begin
      r = v;
    end else begin
      r = v + 16'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/dm_line_store.sv
// Valid/tag/data arrays of the cache: combinational read by index, one write port
// that either fills a whole line (tag + valid) or updates a single word in place.
module dm_line_store
  import cache_pkg::*;
#(
  parameter int LINES = 4,
  parameter int IDX_W = $clog2(LINES)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [IDX_W-1:0]    rd_idx_i,
  output logic                rd_valid_o,
  output logic [BLOCK_W-1:0]  rd_tag_o,
  output logic [LINE_W-1:0]   rd_line_o,
  input  logic                wr_en_i,
  input  logic                wr_fill_i,
  input  logic [IDX_W-1:0]    wr_idx_i,
  input  logic [BLOCK_W-1:0]  wr_tag_i,
  input  logic [OFFSET_W-1:0] wr_off_i,
  input  logic [WORD_W-1:0]   wr_word_i,
  input  logic [LINE_W-1:0]   wr_line_i
);

  // The full block number is kept as tag so the compare works for every LINES value.
  logic [LINES-1:0]   valid_q, valid_d;
  logic [BLOCK_W-1:0] tag_q  [LINES];
  logic [BLOCK_W-1:0] tag_d  [LINES];
  logic [LINE_W-1:0]  data_q [LINES];
  logic [LINE_W-1:0]  data_d [LINES];

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_line_o  = data_q[rd_idx_i];

  // Next-state of the arrays from the single write port.
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (wr_en_i && wr_fill_i) begin
      valid_d[wr_idx_i] = 1'b1;
      tag_d[wr_idx_i]   = wr_tag_i;
      data_d[wr_idx_i]  = wr_line_i;
    end else if (wr_en_i) begin
      data_d[wr_idx_i]  = set_word(data_q[wr_idx_i], wr_off_i, wr_word_i);
    end else begin
      valid_d = valid_q;
    end
  end

  // Valid bits are the only state that must be cleared on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Tag and data payload.
  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

endmodule

// File: rtl/dm_cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate cache controller with 4-word lines.
// Optional hit/miss counters are built when DM_CACHE_STATS_EN is defined.
module dm_cache_ctrl
  import cache_pkg::*;
#(
  parameter int LINES   = 4,
  parameter int MEM_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [31:0]   cpu_addr,
  input  logic [31:0]   cpu_wdata,
  output logic [31:0]   cpu_rdata,
  output logic          cpu_ready,
  output logic          mem_en,
  output logic          mem_w,
  output logic [31:0]   mem_addr,
  output logic [31:0]   mem_din,
  input  logic [127:0]  mem_dout
`ifdef DM_CACHE_STATS_EN
  ,
  output logic [15:0]   hit_cnt,
  output logic [15:0]   miss_cnt
`endif
);

  localparam int IDX_W = $clog2(LINES);
  localparam logic [2:0] LAST_CNT = 3'(MEM_LAT - 1);

  state_e        state_q, state_d;
  logic [5:0]    addr_q, addr_d;
  logic          we_q, we_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          hit_q, hit_d;
  logic [2:0]    cnt_q, cnt_d;
  logic          cpu_ready_q, cpu_ready_d;
  logic [31:0]   cpu_rdata_q, cpu_rdata_d;
  logic          mem_en_q, mem_en_d;
  logic          mem_w_q, mem_w_d;
  logic [31:0]   mem_addr_q, mem_addr_d;
  logic [31:0]   mem_din_q, mem_din_d;

  logic [BLOCK_W-1:0]  blk_s;
  logic [OFFSET_W-1:0] off_s;
  logic [IDX_W-1:0]    idx_s;
  logic                rd_valid_s;
  logic [BLOCK_W-1:0]  rd_tag_s;
  logic [LINE_W-1:0]   rd_line_s;
  logic                hit_s;
  logic                ls_wr_en_s;
  logic                ls_fill_s;
  logic [31:0]         fill_addr_s;
  logic [25:0]         unused_addr_s;

  assign unused_addr_s = cpu_addr[31:6];
  assign blk_s       = addr_q[5:2];
  assign off_s       = addr_q[1:0];
  assign idx_s       = blk_s[IDX_W-1:0];
  assign hit_s       = rd_valid_s && (rd_tag_s == blk_s);
  assign fill_addr_s = {blk_s, 28'd0};

  dm_line_store #(.LINES(LINES)) u_store (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_idx_i   (idx_s),
    .rd_valid_o (rd_valid_s),
    .rd_tag_o   (rd_tag_s),
    .rd_line_o  (rd_line_s),
    .wr_en_i    (ls_wr_en_s),
    .wr_fill_i  (ls_fill_s),
    .wr_idx_i   (idx_s),
    .wr_tag_i   (blk_s),
    .wr_off_i   (off_s),
    .wr_word_i  (wdata_q),
    .wr_line_i  (mem_dout)
  );

  // FSM next state and next values of the registered outputs.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    hit_d       = hit_q;
    cnt_d       = cnt_q;
    cpu_ready_d = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    mem_en_d    = 1'b0;
    mem_w_d     = 1'b0;
    mem_addr_d  = 32'd0;
    mem_din_d   = 32'd0;
    ls_wr_en_s  = 1'b0;
    ls_fill_s   = 1'b0;
    case (state_q)
      IDLE: begin
        if (cpu_req) begin
          state_d = CMP;
          addr_d  = cpu_addr[5:0];
          we_d    = cpu_we;
          wdata_d = cpu_wdata;
        end else begin
          state_d = IDLE;
        end
      end
      CMP: begin
        hit_d = hit_s;
        if (we_q) begin
          state_d    = WRITE;
          mem_en_d   = 1'b1;
          mem_w_d    = 1'b1;
          mem_addr_d = {26'd0, addr_q};
          mem_din_d  = wdata_q;
        end else if (hit_s) begin
          state_d     = RESP;
          cpu_ready_d = 1'b1;
          cpu_rdata_d = word_of_line(rd_line_s, off_s);
        end else begin
          state_d    = FILL;
          cnt_d      = 3'd0;
          mem_en_d   = 1'b1;
          mem_addr_d = fill_addr_s;
        end
      end
      FILL: begin
        // mem_dout is captured on the last edge of the MEM_LAT-cycle enable window.
        if (cnt_q == LAST_CNT) begin
          ls_wr_en_s  = 1'b1;
          ls_fill_s   = 1'b1;
          cpu_rdata_d = word_of_line(mem_dout, off_s);
          cpu_ready_d = 1'b1;
          state_d     = RESP;
        end else begin
          cnt_d      = cnt_q + 3'd1;
          mem_en_d   = 1'b1;
          mem_addr_d = fill_addr_s;
        end
      end
      WRITE: begin
        ls_wr_en_s  = hit_q;
        cpu_ready_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Controller state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= 6'd0;
      we_q        <= 1'b0;
      wdata_q     <= 32'd0;
      hit_q       <= 1'b0;
      cnt_q       <= 3'd0;
      cpu_ready_q <= 1'b0;
      cpu_rdata_q <= 32'd0;
      mem_en_q    <= 1'b0;
      mem_w_q     <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_din_q   <= 32'd0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      hit_q       <= hit_d;
      cnt_q       <= cnt_d;
      cpu_ready_q <= cpu_ready_d;
      cpu_rdata_q <= cpu_rdata_d;
      mem_en_q    <= mem_en_d;
      mem_w_q     <= mem_w_d;
      mem_addr_q  <= mem_addr_d;
      mem_din_q   <= mem_din_d;
    end
  end

  assign cpu_ready = cpu_ready_q;
  assign cpu_rdata = cpu_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_w     = mem_w_q;
  assign mem_addr  = mem_addr_q;
  assign mem_din   = mem_din_q;

`ifdef DM_CACHE_STATS_EN
  logic [15:0] hit_cnt_q, hit_cnt_d;
  logic [15:0] miss_cnt_q, miss_cnt_d;

  // Loads are classified in CMP; stores never touch the counters.
  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (state_q == CMP && !we_q) begin
      if (hit_s) begin
        hit_cnt_d = sat_inc16(hit_cnt_q);
      end else begin
        miss_cnt_d = sat_inc16(miss_cnt_q);
      end
    end else begin
      hit_cnt_d = hit_cnt_q;
    end
  end

  // Saturating hit/miss counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_q  <= 16'd0;
      miss_cnt_q <= 16'd0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: doc/dm_cache_ctrl.md
Name: dm_cache_ctrl

Overview:
- Direct-mapped, write-through, no-write-allocate cache controller that sits between the CPU load/store port and the main memory block.
- Holds a small line store of 4-word lines.
- On a read miss it sequences a 128-bit block read from main memory and fills the line.
- On a write it issues a single-word write to main memory and updates the line if the line is resident.

Parameters:
- LINES, 4, number of cache lines (power of 2, 2..16); index = low log2(LINES) bits of the block number.
- MEM_LAT, 1, cycles main memory needs between mem_en and valid mem_dout (1..7).

Ports:
- clk  in  1  single clock; all state changes on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- cpu_req  in  1  request valid; held high until cpu_ready.
- cpu_we  in  1  1 = store, 0 = load.
- cpu_addr  in  32  word address; only [5:0] used (block = [5:2], offset = [1:0]).
- cpu_wdata  in  32  store data.
- cpu_rdata  out  32  load data, valid while cpu_ready = 1.
- cpu_ready  out  1  one-cycle completion pulse.
- mem_en  out  1  main memory enable.
- mem_w  out  1  main memory write strobe.
- mem_addr  out  32  read: {block,28'b0}; write: {26'b0,addr[5:0]}.
- mem_din  out  32  main memory write data.
- mem_dout  in  128  block read data; word k at [127-32k -: 32].

Behaviour:
- Reset (async, any state): FSM to IDLE; all valid bits cleared; cpu_ready, mem_en, mem_w = 0; cpu_rdata, mem_addr, mem_din = 0; cycle counter = 0. Tag/data arrays need no reset.
- States:
  - IDLE: if cpu_req, latch addr/we/wdata and go to CMP.
  - CMP: hit = valid[idx] && tag[idx] == addr[5:(2+log2 LINES)].
    - load hit: to RESP with cpu_rdata = line word.
    - load miss: to FILL.
    - store: to WRITE.
  - FILL: mem_en = 1, mem_w = 0, mem_addr = {block,28'b0} for exactly MEM_LAT cycles. At the final posedge, capture mem_dout into data[idx], set tag and valid, select the offset word into cpu_rdata, and go to RESP.
  - WRITE: mem_en = 1, mem_w = 1, mem_addr = {26'b0,addr}, mem_din = wdata for one cycle. If the hit flag latched in CMP is set, update that word in the line; otherwise leave the line untouched (no allocate). Go to RESP.
  - RESP: cpu_ready = 1 for one cycle; go to IDLE.
- Latency, measured in cycles from the accepting edge to the cpu_ready cycle:
  - load hit: 2.
  - load miss: 2 + MEM_LAT.
  - store: 3.
- mem_* outputs are registered, glitch-free, and 0 outside FILL/WRITE.
- cpu_req is sampled only in IDLE. Changes while busy are ignored. A request held through RESP is re-accepted in the following IDLE cycle, so a back-to-back accept has one bubble.
- Conflict miss silently overwrites the line; write-through means there is never dirty data.
- Reset during FILL: line stays invalid. Reset during WRITE: memory write may or may not complete; the cache holds no stale copy because all valid bits are cleared.

Optional Feature:
- Macro: DM_CACHE_STATS_EN.
- When defined: outputs hit_cnt[15:0] and miss_cnt[15:0].
  - Each increments once per load in CMP (hit or miss); stores are not counted.
  - Both saturate at 16'hFFFF and reset to 0.
- When undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package cache_pkg holds:
  - state enum {IDLE, CMP, FILL, WRITE, RESP};
  - OFFSET_W = 2, BLOCK_W = 4, WORD_W = 32, LINE_W = 128;
  - function word_of_line(line, off).
- Sub-module dm_line_store: valid/tag/data arrays, with combinational read by index and one write port (full-line fill or single-word update). Valid bits are cleared by rst_n.
- The controller FSM and MEM_LAT counter stay in dm_cache_ctrl.

Test Plan:
- Cold load addr 5 after reset, using main memory preload (mem[5] = 238335, MEM_LAT = 1):
  - FILL with mem_addr = 32'h1000_0000;
  - cpu_ready on cycle 3 with cpu_rdata = 238335;
  - repeat load of addr 5 → no mem_en, cpu_ready on cycle 2, same data.
- Conflict: load 5, then load 21 (same index 1, tag 1):
  - second load misses, mem_addr = 32'h5000_0000, rdata = 595368;
  - load 5 again misses and returns 238335.
- Store hit: load 6 (885386), then store addr 6 data 32'hDEAD_BEEF:
  - one cycle with mem_en = mem_w = 1, mem_addr = 6, mem_din = DEADBEEF;
  - next load 6 hits and returns DEADBEEF.
- Store miss, no allocate: store addr 40 data 7:
  - memory write occurs, valid[2] remains 0;
  - load 40 then misses, mem_addr = 32'hA000_0000, returns 7.
- Reset mid-FILL: assert rst_n = 0 during FILL of addr 12:
  - all outputs 0 immediately, state IDLE;
  - after release, load 12 misses again and returns 368690.
- DM_CACHE_STATS_EN: two loads of addr 5 from cold → hit_cnt = 1, miss_cnt = 1; stores leave both unchanged.
